// File: rtl/alu_32b.sv
// alu_32b: registered 32-bit integer ALU (AND/ADD/SUB/XOR/NOR/OR/SLT/MULT) for the execute stage.
// Latency: one cycle; the result register captures f(value1, value2, select) on every rising edge.
// Backpressure: none; the unit accepts one operation per cycle and never stalls.
module alu_32b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value1,
  input  logic [31:0] value2,
  input  logic [2:0]  select,
  output logic [31:0] result
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_MULT = 3'b111;

  logic [31:0] result_d;
  logic [31:0] result_q;
  logic [32:0] diff_ext;
  logic        lt_signed;
  logic [31:0] prod_lo;

  // Shared datapath terms: sign-extended difference for SLT, low product word for MULT.
  always_comb begin
    // One extra bit keeps the true sign even when the 32-bit subtraction overflows,
    // so the most-negative vs most-positive comparison resolves correctly.
    diff_ext  = {value1[31], value1} - {value2[31], value2};
    lt_signed = diff_ext[32];
    // The low word of a product is the same for signed and unsigned operands,
    // so a 32x32 -> 32 multiply is sufficient.
    prod_lo   = value1 * value2;
  end

  // Next-result selection: pure function of the current operands and opcode.
  always_comb begin
    result_d = 32'h0000_0000;
    case (select)
      OP_AND:  result_d = value1 & value2;
      OP_ADD:  result_d = value1 + value2;
      OP_SUB:  result_d = value1 - value2;
      OP_XOR:  result_d = value1 ^ value2;
      OP_NOR:  result_d = ~(value1 | value2);
      OP_OR:   result_d = value1 | value2;
      OP_SLT:  result_d = {31'd0, lt_signed};
      OP_MULT: result_d = prod_lo;
      default: result_d = 32'h0000_0000;
    endcase
  end

  // Result register; asynchronous reset clears it immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'h0000_0000;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_32b.sv
// tb_alu_32b: scoreboard bench for alu_32b.
// Driver issues one vector per cycle at the falling edge and queues its expected result;
// a monitor pops and compares one entry 1 time unit after each rising edge while out of reset.
module tb_alu_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value1;
  logic [31:0] value2;
  logic [2:0]  select;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  alu_32b dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .value1 (value1),
    .value2 (value2),
    .select (select),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Independent reference used only for the random back-to-back section.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    longint p;
    logic [63:0] pw;
    case (op)
      3'd0: return a & b;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a ^ b;
      3'd4: return ~(a | b);
      3'd5: return a | b;
      3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        pw = p;
        return pw[31:0];
      end
    endcase
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] exp, input string nm);
    @(negedge clk);
    value1 = a;
    value2 = b;
    select = op;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Monitor: every captured edge out of reset corresponds to the oldest queued vector.
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      check(name_q.pop_front(), result, exp_q.pop_front());
    end
  end

  logic [31:0] small_exp [8];
  logic [31:0] pat_exp   [8];

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    small_exp = '{32'h0000_0021, 32'h0000_005C, 32'h0000_000A, 32'h0000_001A,
                  32'hFFFF_FFC4, 32'h0000_003B, 32'h0000_0000, 32'h0000_082B};
    pat_exp   = '{32'h2222_2222, 32'hDDDD_DDDD, 32'h7777_7777, 32'h9999_9999,
                  32'h4444_4444, 32'hBBBB_BBBB, 32'h0000_0001, 32'hDDDD_DDDE};

    // Reset held with non-trivial inputs: result must stay zero across edges.
    rst_n  = 1'b0;
    value1 = 32'h0000_0033;
    value2 = 32'h0000_0029;
    select = 3'd7;
    #1;
    check("reset_initial", result, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", result, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_pre_edge", result, 32'h0);

    // Small operands, all opcodes.
    for (int i = 0; i < 8; i++)
      issue(32'h0000_0033, 32'h0000_0029, 3'(i), small_exp[i], $sformatf("small_op%0d", i));

    // Alternating-bit patterns, all opcodes.
    for (int i = 0; i < 8; i++)
      issue(32'hAAAA_AAAA, 32'h3333_3333, 3'(i), pat_exp[i], $sformatf("pattern_op%0d", i));

    // SLT extremes and equality.
    issue(32'h8000_0000, 32'h7FFF_FFFF, 3'd6, 32'd1, "slt_min_vs_max");
    issue(32'h7FFF_FFFF, 32'h8000_0000, 3'd6, 32'd0, "slt_max_vs_min");
    issue(32'h1234_5678, 32'h1234_5678, 3'd6, 32'd0, "slt_equal");
    issue(32'hFFFF_FFFF, 32'h0000_0000, 3'd6, 32'd1, "slt_neg1_vs_0");

    // Wraparound and multiply sign handling.
    issue(32'h7FFF_FFFF, 32'h0000_0001, 3'd1, 32'h8000_0000, "add_wrap");
    issue(32'h0000_0000, 32'h0000_0001, 3'd2, 32'hFFFF_FFFF, "sub_wrap");
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 32'h0000_0001, "mult_neg_neg");
    issue(32'h0001_0000, 32'h0001_0000, 3'd7, 32'h0000_0000, "mult_overflow_low");
    issue(32'hFFFF_FFFE, 32'h0000_0003, 3'd7, 32'hFFFF_FFFA, "mult_neg_pos");

    // Back-to-back random vectors, new inputs every cycle.
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 3'($urandom_range(7));
      issue(ra, rb, rop, ref_alu(ra, rb, rop), $sformatf("random_%0d_op%0d", i, rop));
    end

    // Mid-stream asynchronous reset.
    issue(32'hDEAD_BEEF, 32'h0000_0000, 3'd5, 32'hDEAD_BEEF, "pre_reset_value");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", result, 32'h0);
    @(negedge clk);
    value1 = 32'h0000_0005;
    value2 = 32'h0000_0007;
    select = 3'd1;
    @(posedge clk);
    #1;
    check("reset_mid_hold", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_mid_release_pre_edge", result, 32'h0);
    @(posedge clk);
    #1;
    check("first_edge_after_release", result, 32'h0000_000C);

    // Resume normal traffic after reset.
    issue(32'h0000_00F0, 32'h0000_0F0F, 3'd4, 32'hFFFF_F000, "post_reset_nor");
    issue(32'hFFFF_FFFD, 32'h0000_0004, 3'd2, 32'hFFFF_FFF9, "post_reset_sub");

    // Bounded drain: every queued expectation must have been consumed.
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
